// File: rtl/l2cache_assoc_param.sv
// l2cache_assoc_param: parametrised write-back, write-allocate, N-way
// set-associative L2 cache with an integrated miss/writeback controller.
// Tree pseudo-LRU replacement with invalid-way-first victim selection.
// Optional feature macro: L2_PERF_CNT_EN (hit/miss/writeback counters;
// when undefined the perf_* ports are tied to zero).
module l2cache_assoc_param #(
  parameter int WAYS       = 4,
  parameter int SETS       = 32,
  parameter int LINE_BITS  = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [LINE_BITS-1:0]  mem_wdata,
  output logic [LINE_BITS-1:0]  mem_rdata,
  output logic                  mem_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_BITS-1:0]  pmem_wdata,
  input  logic [LINE_BITS-1:0]  pmem_rdata,
  input  logic                  pmem_resp,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses,
  output logic [31:0]           perf_writebacks
);

  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int PLRU_BITS   = WAYS - 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  // Storage arrays
  logic [LINE_BITS-1:0] data_arr  [WAYS][SETS];
  logic [TAG_BITS-1:0]  tag_arr   [WAYS][SETS];
  logic [SETS-1:0]      valid_arr [WAYS];
  logic [SETS-1:0]      dirty_arr [WAYS];
  logic [PLRU_BITS-1:0] plru_arr  [SETS];

  state_t                state;
  logic [WAY_BITS-1:0]   victim_q;
  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_index;

  // Request decode; offset bits are intentionally ignored
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic                  req;
  logic                  req_write;
  logic                  unused_offset;

  assign req_tag       = mem_address[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_index     = mem_address[OFFSET_BITS +: INDEX_BITS];
  assign req           = mem_read | mem_write;
  assign req_write     = mem_write;  // read+write together behaves as a write
  assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

  // Walk the tree from the root; a 0 bit sends the search to the left child.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits);
    int   node;
    logic d;
    plru_victim = '0;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      d = 1'b0;
      for (int n = 0; n < PLRU_BITS; n++)
        if (n == node) d = bits[n];
      plru_victim[WAY_BITS-1-l] = d;
      node = 2 * node + 1 + int'(d);
    end
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [PLRU_BITS-1:0] plru_update(input logic [PLRU_BITS-1:0] bits,
                                                       input logic [WAY_BITS-1:0]  way);
    int   node;
    logic d;
    plru_update = bits;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      d = way[WAY_BITS-1-l];
      for (int n = 0; n < PLRU_BITS; n++)
        if (n == node) plru_update[n] = ~d;
      node = 2 * node + 1 + int'(d);
    end
  endfunction

  // Tag compare across all ways of the addressed set
  logic                 hit;
  logic [WAY_BITS-1:0]  hit_way;
  logic [LINE_BITS-1:0] hit_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][req_index] && (tag_arr[w][req_index] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  assign hit_data = data_arr[hit_way][req_index];

  // Victim choice: lowest-numbered invalid way, else the PLRU way
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] victim_way;
  logic                victim_dirty;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[w][req_index]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    victim_way = inv_found ? inv_way : plru_victim(plru_arr[req_index]);
  end

  assign victim_dirty = valid_arr[victim_way][req_index] & dirty_arr[victim_way][req_index];

  // Per-cycle events
  logic hit_fire;
  logic miss_fire;
  logic fill_done;
  logic wb_done;

  assign hit_fire  = (state == IDLE) && req && hit && !rst;
  assign miss_fire = (state == IDLE) && req && !hit && !rst;
  assign fill_done = (state == FILL) && pmem_resp && !rst;
  assign wb_done   = (state == WRITEBACK) && pmem_resp && !rst;

  assign mem_resp  = hit_fire;
  assign mem_rdata = hit_fire ? hit_data : '0;

  // Controller FSM: sequences writeback and fill, drives the pmem interface
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      victim_q     <= '0;
      lat_tag      <= '0;
      lat_index    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_fire) begin
            victim_q  <= victim_way;
            lat_tag   <= req_tag;
            lat_index <= req_index;
            if (victim_dirty) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {tag_arr[victim_way][req_index], req_index, {OFFSET_BITS{1'b0}}};
              pmem_wdata   <= data_arr[victim_way][req_index];
            end else begin
              state        <= FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state        <= FILL;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {lat_tag, lat_index, {OFFSET_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state     <= IDLE;
            pmem_read <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Metadata: valid, dirty and PLRU bits, all cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_arr[w] <= '0;
        dirty_arr[w] <= '0;
      end
      for (int s = 0; s < SETS; s++)
        plru_arr[s] <= '0;
    end else begin
      if (hit_fire) begin
        plru_arr[req_index] <= plru_update(plru_arr[req_index], hit_way);
        if (req_write) dirty_arr[hit_way][req_index] <= 1'b1;
      end
      if (fill_done) begin
        valid_arr[victim_q][lat_index] <= 1'b1;
        dirty_arr[victim_q][lat_index] <= 1'b0;
      end
    end
  end

  // Data and tag arrays: written on write hit and on fill completion
  // NOTE: data/tag storage has no reset; the cleared valid bits make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (hit_fire && req_write)
      data_arr[hit_way][req_index] <= mem_wdata;
    if (fill_done) begin
      data_arr[victim_q][lat_index] <= pmem_rdata;
      tag_arr[victim_q][lat_index]  <= lat_tag;
    end
  end

`ifdef L2_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (hit_fire && (perf_hits != 32'hFFFF_FFFF))
        perf_hits <= perf_hits + 32'd1;
      if (miss_fire && (perf_misses != 32'hFFFF_FFFF))
        perf_misses <= perf_misses + 32'd1;
      if (wb_done && (perf_writebacks != 32'hFFFF_FFFF))
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`else
  logic unused_wb_done;
  assign unused_wb_done  = wb_done;
  assign perf_hits       = '0;
  assign perf_misses     = '0;
  assign perf_writebacks = '0;
`endif

endmodule

// File: tb/tb_l2cache_assoc_param.sv
// Directed self-checking bench for l2cache_assoc_param. Instance A uses the
// default 4-way/32-set geometry, instance B is 8-way/16-set; a select flag
// routes stimulus to one instance at a time and muxes its outputs back.
module tb_l2cache_assoc_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic [255:0] a_mem_rdata, b_mem_rdata, a_pmem_wdata, b_pmem_wdata;
  logic [31:0]  a_pmem_address, b_pmem_address;
  logic         a_mem_resp, b_mem_resp, a_pmem_read, b_pmem_read, a_pmem_write, b_pmem_write;
  logic [31:0]  a_hits, a_misses, a_wbs, b_hits, b_misses, b_wbs;

  int total = 0;
  int bad   = 0;
  int exp_hits, exp_misses, exp_wbs;

  always #5 clk = ~clk;

  l2cache_assoc_param #(.WAYS(4), .SETS(32), .LINE_BITS(256), .ADDR_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .mem_address(mem_address),
    .mem_read(mem_read & ~sel), .mem_write(mem_write & ~sel), .mem_wdata(mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp), .pmem_address(a_pmem_address),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write), .pmem_wdata(a_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & ~sel),
    .perf_hits(a_hits), .perf_misses(a_misses), .perf_writebacks(a_wbs)
  );

  l2cache_assoc_param #(.WAYS(8), .SETS(16), .LINE_BITS(256), .ADDR_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .mem_address(mem_address),
    .mem_read(mem_read & sel), .mem_write(mem_write & sel), .mem_wdata(mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp), .pmem_address(b_pmem_address),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_wdata(b_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & sel),
    .perf_hits(b_hits), .perf_misses(b_misses), .perf_writebacks(b_wbs)
  );

  wire [255:0] o_mem_rdata    = sel ? b_mem_rdata    : a_mem_rdata;
  wire         o_mem_resp     = sel ? b_mem_resp     : a_mem_resp;
  wire [31:0]  o_pmem_address = sel ? b_pmem_address : a_pmem_address;
  wire         o_pmem_read    = sel ? b_pmem_read    : a_pmem_read;
  wire         o_pmem_write   = sel ? b_pmem_write   : a_pmem_write;
  wire [255:0] o_pmem_wdata   = sel ? b_pmem_wdata   : a_pmem_wdata;
  wire [31:0]  o_hits         = sel ? b_hits         : a_hits;
  wire [31:0]  o_misses       = sel ? b_misses       : a_misses;
  wire [31:0]  o_wbs          = sel ? b_wbs          : a_wbs;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  // Hold memory response low for 2 more cycles, then pulse it with data.
  task automatic mem_reply(input logic [255:0] data);
    repeat (2) @(negedge clk);
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    #1;
  endtask

  // One upstream request, with hand-computed hit/writeback expectations.
  task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [255:0] wdata, input logic exp_hit, input logic exp_wb,
                        input logic [31:0] wb_addr, input logic [255:0] wb_data,
                        input logic [255:0] fill_data, input logic [255:0] exp_rdata);
    mem_address = addr;
    mem_read    = ~wr;
    mem_write   = wr;
    mem_wdata   = wdata;
    #1;
    if (!exp_hit) begin
      check({tag, ".miss_noresp"}, {255'd0, o_mem_resp}, 256'd0);
      exp_misses++;
      @(negedge clk);
      if (exp_wb) begin
        exp_wbs++;
        check({tag, ".wb_write"}, {254'd0, o_pmem_write, o_pmem_read}, 256'd2);
        check({tag, ".wb_addr"}, {224'd0, o_pmem_address}, {224'd0, wb_addr});
        check({tag, ".wb_data"}, o_pmem_wdata, wb_data);
        mem_reply('0);
      end
      check({tag, ".fill_read"}, {254'd0, o_pmem_write, o_pmem_read}, 256'd1);
      check({tag, ".fill_addr"}, {224'd0, o_pmem_address}, {224'd0, addr & 32'hFFFF_FFE0});
      mem_reply(fill_data);
    end
    exp_hits++;
    check({tag, ".resp"}, {255'd0, o_mem_resp}, 256'd1);
    check({tag, ".rdata"}, o_mem_rdata, exp_rdata);
    check({tag, ".pmem_idle"}, {254'd0, o_pmem_write, o_pmem_read}, 256'd0);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic check_perf(input string tag);
`ifdef L2_PERF_CNT_EN
    check({tag, ".hits"},   {224'd0, o_hits},   256'(exp_hits));
    check({tag, ".misses"}, {224'd0, o_misses}, 256'(exp_misses));
    check({tag, ".wbs"},    {224'd0, o_wbs},    256'(exp_wbs));
`else
    check({tag, ".hits"},   {224'd0, o_hits},   256'd0);
    check({tag, ".misses"}, {224'd0, o_misses}, 256'd0);
    check({tag, ".wbs"},    {224'd0, o_wbs},    256'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] la, lb, l1, l2, l3, ld, la2, w8;
    la  = line(32'hAAAA_0001);
    lb  = line(32'hBBBB_0002);
    l1  = line(32'h1111_0440);
    l2  = line(32'h2222_0840);
    l3  = line(32'h3333_0C40);
    ld  = line(32'hDDDD_1040);
    la2 = line(32'hA2A2_0040);
    w8  = line(32'h5EED_0000);

    rst = 1'b1; sel = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.mem_resp",  {255'd0, o_mem_resp}, 256'd0);
    check("reset.mem_rdata", o_mem_rdata, 256'd0);
    check("reset.pmem_rw",   {254'd0, o_pmem_write, o_pmem_read}, 256'd0);
    check("reset.pmem_addr", {224'd0, o_pmem_address}, 256'd0);
    check("reset.pmem_wdata", o_pmem_wdata, 256'd0);
    @(negedge clk);
    check("idle.no_resp", {255'd0, o_mem_resp}, 256'd0);

    // 4-way: index 2 for all of 0x40/0x440/0x840/0xC40/0x1040
    access("rd40",   32'h40,   1'b0, '0, 1'b0, 1'b0, '0, '0, la, la);
    access("rehit40", 32'h40,  1'b0, '0, 1'b1, 1'b0, '0, '0, '0, la);
    access("wr40",   32'h40,   1'b1, lb, 1'b1, 1'b0, '0, '0, '0, la);
    access("rdB40",  32'h40,   1'b0, '0, 1'b1, 1'b0, '0, '0, '0, lb);
    access("rd440",  32'h440,  1'b0, '0, 1'b0, 1'b0, '0, '0, l1, l1);
    access("rd840",  32'h840,  1'b0, '0, 1'b0, 1'b0, '0, '0, l2, l2);
    access("rdC40",  32'hC40,  1'b0, '0, 1'b0, 1'b0, '0, '0, l3, l3);
    // Tree after ways 0..3 in order: root=0, node1=0 -> way0 (dirty, holds B)
    access("rd1040", 32'h1040, 1'b0, '0, 1'b0, 1'b1, 32'h40, lb, ld, ld);
    access("hit1040", 32'h1040, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, ld);
    // Tree now root=1, node2=0 -> way2 (clean 0x840): fill only
    access("re40",   32'h40,   1'b0, '0, 1'b0, 1'b0, '0, '0, lb, lb);
    access("keep440", 32'h440, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, l1);
    access("gone840", 32'h840, 1'b0, '0, 1'b0, 1'b0, '0, '0, l2, l2);

    // Reset in the middle of a fill
    mem_address = 32'h2040; mem_read = 1'b1;
    @(negedge clk);
    check("rstfill.pmem_read", {255'd0, o_pmem_read}, 256'd1);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstfill.pmem_rw",   {254'd0, o_pmem_write, o_pmem_read}, 256'd0);
    check("rstfill.pmem_addr", {224'd0, o_pmem_address}, 256'd0);
    pmem_resp = 1'b1; pmem_rdata = line(32'hDEAD_BEEF);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("late_resp.pmem_rw", {254'd0, o_pmem_write, o_pmem_read}, 256'd0);
    check("late_resp.mem_resp", {255'd0, o_mem_resp}, 256'd0);
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    access("post_rst40", 32'h40, 1'b0, '0, 1'b0, 1'b0, '0, '0, la2, la2);
    check_perf("perf4");

    // 8-way/16-set: lines k*0x200+0x20 all land in set 1
    sel = 1'b1;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    access("b_wr0", 32'h20, 1'b1, w8, 1'b0, 1'b0, '0, '0, line(32'hF000_0000), line(32'hF000_0000));
    for (int k = 1; k < 8; k++)
      access($sformatf("b_rd%0d", k), 32'(k) * 32'h200 + 32'h20, 1'b0, '0, 1'b0, 1'b0,
             '0, '0, line(32'hF000_0000 + 32'(k)), line(32'hF000_0000 + 32'(k)));
    // All valid, tree points at way0, which is dirty
    access("b_rd8", 32'h1020, 1'b0, '0, 1'b0, 1'b1, 32'h20, w8, line(32'hF000_0008), line(32'hF000_0008));
    access("b_hit8", 32'h1020, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, line(32'hF000_0008));
    // Victim is now way4 (clean)
    access("b_re0", 32'h20, 1'b0, '0, 1'b0, 1'b0, '0, '0, w8, w8);
    access("b_re4", 32'h820, 1'b0, '0, 1'b0, 1'b0, '0, '0, line(32'hF000_0004), line(32'hF000_0004));
    check_perf("perf8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
